// File: rtl/gb_act_sender_if.sv
// ============================================================================
// Module      : gb_act_sender_if
// Description : Bundles the configuration, GB source and PEB-side handshake
//               channels of gb_act_sender. The master modport is the sender's
//               view; the slave modport is the view of the surrounding logic
//               (GB source, PEB sink and configuration master).
//               Optional statistics outputs exist only when
//               GB_ACT_SENDER_STAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gb_act_sender_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_ACT    = 16,
    parameter int FLG_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16
);
    // Job control
    logic                          CfgStart;
    logic [CNT_WIDTH-1:0]          CfgNumBlk;
    logic                          Busy;
    logic                          Done;

    // GB source: flag words
    logic                          SrcFLG_Val;
    logic                          SrcFLG_Rdy;
    logic [FLG_WIDTH-1:0]          SrcFLG_Data;

    // GB source: packed activation beats
    logic                          SrcACT_Val;
    logic                          SrcACT_Rdy;
    logic [DATA_WIDTH*NUM_ACT-1:0] SrcACT_Data;

    // PEB flag channel
    logic                          GBFLGACT_val;
    logic                          FLGACTGB_rdy;
    logic [FLG_WIDTH-1:0]          GBFLGACT_data;

    // PEB activation channel
    logic                          GBACT_Val;
    logic                          ACTGB_Rdy;
    logic [DATA_WIDTH*NUM_ACT-1:0] GBACT_Data;

`ifdef GB_ACT_SENDER_STAT_EN
    // Per-job statistics
    logic [31:0]                   StatActBeats;
    logic [CNT_WIDTH-1:0]          StatFlgCnt;
`endif

    modport master (
`ifdef GB_ACT_SENDER_STAT_EN
        output StatActBeats, StatFlgCnt,
`endif
        input  CfgStart, CfgNumBlk,
        output Busy, Done,
        input  SrcFLG_Val, SrcFLG_Data,
        output SrcFLG_Rdy,
        input  SrcACT_Val, SrcACT_Data,
        output SrcACT_Rdy,
        output GBFLGACT_val, GBFLGACT_data,
        input  FLGACTGB_rdy,
        output GBACT_Val, GBACT_Data,
        input  ACTGB_Rdy
    );

    modport slave (
`ifdef GB_ACT_SENDER_STAT_EN
        input  StatActBeats, StatFlgCnt,
`endif
        output CfgStart, CfgNumBlk,
        input  Busy, Done,
        output SrcFLG_Val, SrcFLG_Data,
        input  SrcFLG_Rdy,
        output SrcACT_Val, SrcACT_Data,
        input  SrcACT_Rdy,
        input  GBFLGACT_val, GBFLGACT_data,
        output FLGACTGB_rdy,
        input  GBACT_Val, GBACT_Data,
        output ACTGB_Rdy
    );

endinterface

`default_nettype wire

// File: rtl/gb_act_sender.sv
// ============================================================================
// Module      : gb_act_sender
// Description : GB-side transmitter for one PEB. For each of CfgNumBlk blocks
//               it fetches a sparsity flag word, forwards it to the PEB, then
//               fetches and forwards ceil(popcount(flag)/NUM_ACT) packed
//               activation beats through a one-deep register slice.
//               Optional macro GB_ACT_SENDER_STAT_EN adds the StatActBeats
//               and StatFlgCnt counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gb_act_sender #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_ACT    = 16,
    parameter int FLG_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16
) (
    input wire               Clk,
    input wire               Rst,
    gb_act_sender_if.master  bus
);

    // ------------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------------
    localparam int c_ACT_W     = DATA_WIDTH * NUM_ACT;
    localparam int c_POP_W     = $clog2(FLG_WIDTH + 1);
    // Rounding sum must hold popcount + NUM_ACT-1 and the divisor itself.
    localparam int c_PR_W      = $clog2(FLG_WIDTH + NUM_ACT + 1);
    localparam int c_MAX_BEATS = (FLG_WIDTH + NUM_ACT - 1) / NUM_ACT;
    localparam int c_BEAT_W    = $clog2(c_MAX_BEATS + 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH_FLG = 3'd1,
        S_SEND_FLG  = 3'd2,
        S_SEND_ACT  = 3'd3,
        S_NEXT      = 3'd4
    } state_t;

    state_t                 r_State;
    state_t                 w_NextState;

    // Job / block bookkeeping
    logic [CNT_WIDTH-1:0]   r_BlkCnt;
    logic                   r_Done;

    // Flag register slice toward the PEB
    logic [FLG_WIDTH-1:0]   r_FlgData;
    logic                   r_FlgVal;

    // Activation register slice toward the PEB
    logic [c_ACT_W-1:0]     r_ActData;
    logic                   r_ActVal;

    // Beat accounting for the current block
    logic [c_BEAT_W-1:0]    r_BeatsLeft;
    logic [c_BEAT_W-1:0]    r_BeatsFetched;
    logic [c_BEAT_W-1:0]    r_BeatsSent;

    // Combinational helpers
    logic                   w_SrcFlgRdy;
    logic                   w_SrcActRdy;
    logic                   w_StartAcc;
    logic                   w_SrcFlgHs;
    logic                   w_SrcActHs;
    logic                   w_PebFlgHs;
    logic                   w_PebActHs;
    logic                   w_LastBeat;
    logic                   w_LastBlk;
    logic [c_POP_W-1:0]     w_PopCnt;
    logic [c_PR_W-1:0]      w_PopRound;
    logic [c_BEAT_W-1:0]    w_BeatsCalc;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    assign w_StartAcc = (r_State == S_IDLE) && bus.CfgStart;
    assign w_SrcFlgHs = bus.SrcFLG_Val && w_SrcFlgRdy;
    assign w_SrcActHs = bus.SrcACT_Val && w_SrcActRdy;
    assign w_PebFlgHs = r_FlgVal && bus.FLGACTGB_rdy;
    assign w_PebActHs = r_ActVal && bus.ACTGB_Rdy;

    // Only meaningful in S_SEND_ACT, where r_BeatsLeft is at least one.
    assign w_LastBeat = (r_BeatsSent == (r_BeatsLeft - c_BEAT_W'(1)));

    // A zero block count behaves like a single final NEXT visit.
    assign w_LastBlk  = (r_BlkCnt <= CNT_WIDTH'(1));

    // Popcount of the incoming flag word over all FLG_WIDTH bits
    always_comb begin
        w_PopCnt = '0;
        for (int i = 0; i < FLG_WIDTH; i++) begin
            w_PopCnt = w_PopCnt + c_POP_W'(bus.SrcFLG_Data[i]);
        end
    end

    // Beats needed for the incoming flag: ceil(popcount / NUM_ACT)
    assign w_PopRound  = c_PR_W'(w_PopCnt) + c_PR_W'(NUM_ACT - 1);
    assign w_BeatsCalc = c_BEAT_W'(w_PopRound / c_PR_W'(NUM_ACT));

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_State <= S_IDLE;
        end else begin
            r_State <= w_NextState;
        end
    end

    // Next-state and source-ready decode
    always_comb begin
        w_NextState = r_State;
        w_SrcFlgRdy = 1'b0;
        w_SrcActRdy = 1'b0;
        case (r_State)
            S_IDLE: begin
                if (bus.CfgStart) begin
                    w_NextState = (bus.CfgNumBlk == '0) ? S_NEXT : S_FETCH_FLG;
                end
            end
            S_FETCH_FLG: begin
                w_SrcFlgRdy = 1'b1;
                if (bus.SrcFLG_Val) begin
                    w_NextState = S_SEND_FLG;
                end
            end
            S_SEND_FLG: begin
                if (w_PebFlgHs) begin
                    w_NextState = (r_BeatsLeft == '0) ? S_NEXT : S_SEND_ACT;
                end
            end
            S_SEND_ACT: begin
                // Refill the slice when it is empty or draining this cycle.
                w_SrcActRdy = (r_BeatsFetched < r_BeatsLeft) &&
                              (!r_ActVal || bus.ACTGB_Rdy);
                if (w_PebActHs && w_LastBeat) begin
                    w_NextState = S_NEXT;
                end
            end
            S_NEXT: begin
                w_NextState = w_LastBlk ? S_IDLE : S_FETCH_FLG;
            end
            default: begin
                w_NextState = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------

    // Block counter: latched on start, decremented on every NEXT visit
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_BlkCnt <= '0;
        end else if (w_StartAcc) begin
            r_BlkCnt <= bus.CfgNumBlk;
        end else if (r_State == S_NEXT) begin
            r_BlkCnt <= w_LastBlk ? '0 : (r_BlkCnt - CNT_WIDTH'(1));
        end
    end

    // One-cycle Done pulse when the final block's NEXT visit completes
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_Done <= 1'b0;
        end else begin
            r_Done <= (r_State == S_NEXT) && w_LastBlk;
        end
    end

    // Flag slice: load on source handshake, drop on PEB handshake
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_FlgData   <= '0;
            r_FlgVal    <= 1'b0;
            r_BeatsLeft <= '0;
        end else if (w_SrcFlgHs) begin
            r_FlgData   <= bus.SrcFLG_Data;
            r_FlgVal    <= 1'b1;
            r_BeatsLeft <= w_BeatsCalc;
        end else if (w_PebFlgHs) begin
            r_FlgVal    <= 1'b0;
        end
    end

    // Activation slice: a load wins over a concurrent drain so throughput
    // stays at one beat per cycle
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_ActData <= '0;
            r_ActVal  <= 1'b0;
        end else if (w_SrcActHs) begin
            r_ActData <= bus.SrcACT_Data;
            r_ActVal  <= 1'b1;
        end else if (w_PebActHs) begin
            r_ActVal  <= 1'b0;
        end
    end

    // Per-block beat counters, rearmed on each flag fetch
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_BeatsFetched <= '0;
            r_BeatsSent    <= '0;
        end else if (w_SrcFlgHs) begin
            r_BeatsFetched <= '0;
            r_BeatsSent    <= '0;
        end else begin
            if (w_SrcActHs) begin
                r_BeatsFetched <= r_BeatsFetched + c_BEAT_W'(1);
            end
            if (w_PebActHs) begin
                r_BeatsSent <= r_BeatsSent + c_BEAT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------------
`ifdef GB_ACT_SENDER_STAT_EN
    logic [31:0]          r_StatActBeats;
    logic [CNT_WIDTH-1:0] r_StatFlgCnt;

    // Saturating per-job counters of PEB-side handshakes
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_StatActBeats <= '0;
            r_StatFlgCnt   <= '0;
        end else if (w_StartAcc) begin
            r_StatActBeats <= '0;
            r_StatFlgCnt   <= '0;
        end else begin
            if (w_PebActHs && (r_StatActBeats != '1)) begin
                r_StatActBeats <= r_StatActBeats + 32'd1;
            end
            if (w_PebFlgHs && (r_StatFlgCnt != '1)) begin
                r_StatFlgCnt <= r_StatFlgCnt + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.StatActBeats = r_StatActBeats;
    assign bus.StatFlgCnt   = r_StatFlgCnt;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.Busy          = (r_State != S_IDLE);
    assign bus.Done          = r_Done;
    assign bus.SrcFLG_Rdy    = w_SrcFlgRdy;
    assign bus.SrcACT_Rdy    = w_SrcActRdy;
    assign bus.GBFLGACT_val  = r_FlgVal;
    assign bus.GBFLGACT_data = r_FlgData;
    assign bus.GBACT_Val     = r_ActVal;
    assign bus.GBACT_Data    = r_ActData;

endmodule

`default_nettype wire

// File: tb/tb_gb_act_sender.sv
// ============================================================================
// Module      : tb_gb_act_sender
// Description : Self-checking bench for gb_act_sender. A table of directed
//               jobs and a set of randomized jobs are driven through queue
//               based GB sources and a PEB sink; expected flag order, beat
//               counts and beat data come from a block-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gb_act_sender;

    localparam int c_NUM_ACT = 16;
    localparam int c_ACT_W   = 8 * c_NUM_ACT;

    logic Clk;
    logic Rst;

    gb_act_sender_if #(.DATA_WIDTH(8), .NUM_ACT(c_NUM_ACT), .FLG_WIDTH(32), .CNT_WIDTH(16)) bus ();

    gb_act_sender #(.DATA_WIDTH(8), .NUM_ACT(c_NUM_ACT), .FLG_WIDTH(32), .CNT_WIDTH(16)) u_dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.master)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Scoreboard state
    int nVec;
    int nErr;
    logic [31:0]        flgQ[$];
    logic [c_ACT_W-1:0] actQ[$];
    logic [31:0]        expFlg[$];
    logic [31:0]        gotFlg[$];
    logic [c_ACT_W-1:0] expAct[$];
    logic [c_ACT_W-1:0] gotAct[$];
    int                 expPerBlk[$];
    int                 gotPerBlk[$];
    int  doneCnt, doneStep, stepIdx, protoErr, valCycles, rdyMode;
    logic busyAtDone, busyAfterStart;
    bit  startReq, injectEn;
    logic [15:0] startNum;
    bit  prevFlgStall, prevActStall;
    logic [31:0]        prevFlgData;
    logic [c_ACT_W-1:0] prevActData;

    task automatic chk(input string name, input logic [c_ACT_W-1:0] got, input logic [c_ACT_W-1:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    function automatic logic [c_ACT_W-1:0] rand_beat();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One clock: drive at negedge, sample 1 ns later, well before posedge
    task automatic step();
        @(negedge Clk);
        bus.CfgStart  = startReq;
        bus.CfgNumBlk = startNum;
        // A start while the flag channel is stalled must be ignored
        if (!startReq && injectEn && prevFlgStall && ($urandom_range(0, 1) == 1)) begin
            bus.CfgStart  = 1'b1;
            bus.CfgNumBlk = 16'($urandom_range(1, 9));
        end
        bus.SrcFLG_Val  = (flgQ.size() > 0) && (rdyMode != 2 || $urandom_range(0, 3) != 0);
        bus.SrcFLG_Data = (flgQ.size() > 0) ? flgQ[0] : $urandom();
        bus.SrcACT_Val  = (actQ.size() > 0) && (rdyMode != 2 || $urandom_range(0, 3) != 0);
        bus.SrcACT_Data = (actQ.size() > 0) ? actQ[0] : rand_beat();
        case (rdyMode)
            1: begin
                bus.FLGACTGB_rdy = 1'b1;
                bus.ACTGB_Rdy    = (stepIdx % 2 == 0);
            end
            2: begin
                bus.FLGACTGB_rdy = ($urandom_range(0, 1) == 1);
                bus.ACTGB_Rdy    = ($urandom_range(0, 1) == 1);
            end
            default: begin
                bus.FLGACTGB_rdy = 1'b1;
                bus.ACTGB_Rdy    = 1'b1;
            end
        endcase
        #1;
        startReq = 1'b0;
        if (bus.GBFLGACT_val && bus.GBACT_Val) protoErr++;
        if (prevFlgStall && (!bus.GBFLGACT_val || bus.GBFLGACT_data !== prevFlgData)) protoErr++;
        if (prevActStall && (!bus.GBACT_Val || bus.GBACT_Data !== prevActData)) protoErr++;
        if (bus.GBFLGACT_val || bus.GBACT_Val) valCycles++;
        if (bus.SrcFLG_Val && bus.SrcFLG_Rdy && flgQ.size() > 0) void'(flgQ.pop_front());
        if (bus.SrcACT_Val && bus.SrcACT_Rdy && actQ.size() > 0) void'(actQ.pop_front());
        if (bus.GBFLGACT_val && bus.FLGACTGB_rdy) begin
            gotFlg.push_back(bus.GBFLGACT_data);
            gotPerBlk.push_back(0);
        end
        if (bus.GBACT_Val && bus.ACTGB_Rdy) begin
            gotAct.push_back(bus.GBACT_Data);
            if (gotPerBlk.size() > 0) gotPerBlk[gotPerBlk.size()-1]++;
            else protoErr++;
        end
        if (bus.Done) begin
            doneCnt++;
            doneStep   = stepIdx;
            busyAtDone = bus.Busy;
        end
        if (stepIdx == 1) busyAfterStart = bus.Busy;
        prevFlgStall = bus.GBFLGACT_val && !bus.FLGACTGB_rdy;
        prevFlgData  = bus.GBFLGACT_data;
        prevActStall = bus.GBACT_Val && !bus.ACTGB_Rdy;
        prevActData  = bus.GBACT_Data;
        stepIdx++;
    endtask

    task automatic clear_tb();
        flgQ.delete(); actQ.delete();
        expFlg.delete(); gotFlg.delete();
        expAct.delete(); gotAct.delete();
        expPerBlk.delete(); gotPerBlk.delete();
        doneCnt = 0; doneStep = -1; stepIdx = 0; protoErr = 0; valCycles = 0;
        busyAtDone = 1'b1; busyAfterStart = 1'b0;
        startReq = 1'b0; injectEn = 1'b0;
        prevFlgStall = 1'b0; prevActStall = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        clear_tb();
    endtask

    // Runs one job and scores it against the block-level model
    task automatic run_job(input string name, input int numBlk, input logic [31:0] flags[$],
                           input int mode, input int expActTbl, input int expDoneStep, input bit inject);
        int beats;
        int budget;
        int n;
        clear_tb();
        rdyMode = mode;
        for (int b = 0; b < numBlk; b++) begin
            expFlg.push_back(flags[b]);
            flgQ.push_back(flags[b]);
            beats = ($countones(flags[b]) + c_NUM_ACT - 1) / c_NUM_ACT;
            expPerBlk.push_back(beats);
            for (int k = 0; k < beats; k++) begin
                expAct.push_back(rand_beat());
                actQ.push_back(expAct[expAct.size()-1]);
            end
        end
        injectEn = inject;
        startReq = 1'b1;
        startNum = 16'(numBlk);
        budget   = 100 + 40 * numBlk;
        while (doneCnt == 0 && stepIdx < budget) step();
        if (doneCnt == 0) begin
            nVec++;
            nErr++;
            $display("FAIL %s timeout: no Done within %0d cycles, required one Done pulse", name, budget);
            do_reset();
            return;
        end
        injectEn = 1'b0;
        repeat (4) step();

        chk({name, " done_count"}, doneCnt, 1);
        chk({name, " busy_after_start"}, busyAfterStart, 1'b1);
        chk({name, " busy_at_done"}, busyAtDone, 1'b0);
        chk({name, " protocol_errors"}, protoErr, 0);
        chk({name, " flag_count"}, gotFlg.size(), expFlg.size());
        chk({name, " act_count"}, gotAct.size(), expAct.size());
        chk({name, " src_drained"}, flgQ.size() + actQ.size(), 0);
        n = (gotFlg.size() < expFlg.size()) ? gotFlg.size() : expFlg.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s flag[%0d]", name, i), gotFlg[i], expFlg[i]);
            chk($sformatf("%s beats_in_block[%0d]", name, i), gotPerBlk[i], expPerBlk[i]);
        end
        n = (gotAct.size() < expAct.size()) ? gotAct.size() : expAct.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s act[%0d]", name, i), gotAct[i], expAct[i]);
        end
        if (expActTbl >= 0)   chk({name, " act_total"}, gotAct.size(), expActTbl);
        if (expDoneStep >= 0) chk({name, " done_latency"}, doneStep, expDoneStep);
        if (numBlk == 0)      chk({name, " no_peb_val"}, valCycles, 0);
    endtask

    typedef struct {
        int               numBlk;
        logic [2:0][31:0] flg;
        int               mode;
        int               expAct;
        int               expDone;
    } vec_t;

    task automatic chk_outputs_zero(input string name);
        chk({name, " ctrl"}, {bus.Busy, bus.Done, bus.SrcFLG_Rdy, bus.SrcACT_Rdy,
                              bus.GBFLGACT_val, bus.GBACT_Val}, '0);
        chk({name, " flg_data"}, bus.GBFLGACT_data, '0);
        chk({name, " act_data"}, bus.GBACT_Data, '0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        logic [31:0] q[$];
        int          nb;

        nVec = 0;
        nErr = 0;
        rdyMode = 0;
        startNum = '0;
        clear_tb();
        bus.CfgStart = 1'b0; bus.CfgNumBlk = '0;
        bus.SrcFLG_Val = 1'b0; bus.SrcFLG_Data = '0;
        bus.SrcACT_Val = 1'b0; bus.SrcACT_Data = '0;
        bus.FLGACTGB_rdy = 1'b0; bus.ACTGB_Rdy = 1'b0;

        // Directed job table: numBlk, flags (index 0 first), rdy mode,
        // expected ACT handshakes, expected Done step (-1: unchecked)
        tbl[0] = '{1, {32'h0, 32'h0, 32'h0000_FFFF},          0, 1, 6};
        tbl[1] = '{3, {32'h1, 32'hFFFF_FFFF, 32'h0},          0, 3, -1};
        tbl[2] = '{1, {32'h0, 32'h0, 32'hFFFF_FFFF},          1, 2, -1};
        tbl[3] = '{0, {32'h0, 32'h0, 32'h0},                  0, 0, 2};
        tbl[4] = '{2, {32'h0, 32'h0001_FFFF, 32'h8000_0001},  2, 3, -1};
        tbl[5] = '{1, {32'h0, 32'h0, 32'hFFFF_0000},          0, 1, 6};

        Rst = 1'b0;
        #1 Rst = 1'b1;
        #1 chk_outputs_zero("reset_state");
        repeat (3) @(negedge Clk);
        Rst = 1'b0;

        for (int t = 0; t < 6; t++) begin
            q.delete();
            for (int b = 0; b < 3; b++) q.push_back(tbl[t].flg[b]);
            run_job($sformatf("table%0d", t), tbl[t].numBlk, q, tbl[t].mode,
                    tbl[t].expAct, tbl[t].expDone, 1'b0);
        end

        // Reset while the second beat of an all-ones block is in flight
        clear_tb();
        rdyMode = 0;
        flgQ.push_back(32'hFFFF_FFFF);
        actQ.push_back(rand_beat());
        actQ.push_back(rand_beat());
        startReq = 1'b1;
        startNum = 16'd1;
        while (gotAct.size() == 0 && stepIdx < 50) step();
        chk("rstmid first_beat_seen", gotAct.size(), 1);
        @(negedge Clk);
        #2 Rst = 1'b1;
        #1 chk_outputs_zero("rstmid outputs");
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        clear_tb();
        repeat (5) step();
        chk("rstmid no_done", doneCnt, 0);
        chk("rstmid idle_no_val", valCycles, 0);
        q.delete();
        q.push_back(32'h00F0_F0F0);
        run_job("rstmid_rerun", 1, q, 0, 1, 6, 1'b0);

        // Randomized jobs with stalls on every channel and ignored restarts
        for (int j = 0; j < 25; j++) begin
            q.delete();
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                case ($urandom_range(0, 4))
                    0: q.push_back(32'h0);
                    1: q.push_back(32'hFFFF_FFFF);
                    2: q.push_back($urandom());
                    3: q.push_back(32'h1 << $urandom_range(0, 31));
                    default: q.push_back($urandom() & $urandom());
                endcase
            end
            run_job($sformatf("rand%0d", j), nb, q, 2, -1, -1, 1'b1);
        end

`ifdef GB_ACT_SENDER_STAT_EN
        q.delete();
        q.push_back(32'hFFFF_0000);
        q.push_back(32'hFFFF_0000);
        run_job("stat", 2, q, 0, 2, -1, 1'b0);
        chk("stat act_beats", bus.StatActBeats, 2);
        chk("stat flg_cnt", bus.StatFlgCnt, 2);
        q.delete();
        run_job("stat_clear", 0, q, 0, 0, 2, 1'b0);
        chk("stat act_beats_cleared", bus.StatActBeats, 0);
        chk("stat flg_cnt_cleared", bus.StatFlgCnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gb_act_sender.md
Name: gb_act_sender

Overview:
- GB-side transmitter feeding one PEB's activation and activation-flag input channels (GBFLGACT_* / GBACT_*).
- Per block, the sender fetches one 32-bit sparsity flag word from the GB source and forwards it to the PEB.
- It then fetches and forwards exactly ceil(popcount(flag)/NUM_ACT) packed activation beats.
- One instance per PEB; a block count is programmed per layer.

Parameters:
- DATA_WIDTH, 8, activation element width.
- NUM_ACT, 16, activation elements per ACT beat.
- FLG_WIDTH, 32, flag bits per block.
- CNT_WIDTH, 16, width of block counter.

Ports:
- Clk  in  1  clock
- Rst  in  1  asynchronous active-high reset
- CfgStart  in  1  start pulse; sampled only in IDLE
- CfgNumBlk  in  CNT_WIDTH  blocks to send; latched on accepted CfgStart
- Busy  out  1  high from accepted start until Done
- Done  out  1  one-cycle pulse at end of job
- SrcFLG_Val  in  1  GB flag word valid
- SrcFLG_Rdy  out  1  sender accepts flag word
- SrcFLG_Data  in  FLG_WIDTH  flag word
- SrcACT_Val  in  1  GB activation beat valid
- SrcACT_Rdy  out  1  sender accepts activation beat
- SrcACT_Data  in  DATA_WIDTH*NUM_ACT  packed activations
- GBFLGACT_val  out  1  flag valid to PEB
- FLGACTGB_rdy  in  1  PEB flag ready
- GBFLGACT_data  out  FLG_WIDTH  flag to PEB
- GBACT_Val  out  1  activation valid to PEB
- ACTGB_Rdy  in  1  PEB activation ready
- GBACT_Data  out  DATA_WIDTH*NUM_ACT  activations to PEB

Behaviour:
- Reset (async, Rst=1):
  - All outputs go to 0; state goes to IDLE; counters clear.
  - Reset mid-job abandons the job with no Done pulse.
- A handshake on any channel is Val && Rdy at the rising edge of Clk.
- Output val, once raised, holds until its rdy. Output data stays stable while val=1 && rdy=0.
- FSM states and transitions:
  - IDLE: Busy=0. On CfgStart:
    - latch NumBlk; set Busy=1;
    - if NumBlk==0, pulse Done next cycle and return to IDLE;
    - otherwise go to FETCH_FLG.
  - FETCH_FLG: SrcFLG_Rdy=1. On handshake:
    - register the flag into GBFLGACT_data; GBFLGACT_val=1 next cycle;
    - compute BeatsLeft = (popcount(flag)+NUM_ACT-1)/NUM_ACT (0..2 at defaults);
    - go to SEND_FLG.
  - SEND_FLG: wait for the PEB flag handshake, then clear GBFLGACT_val.
    - BeatsLeft==0 goes to NEXT.
    - Otherwise go to SEND_ACT.
  - SEND_ACT: SrcACT_Rdy = (BeatsFetched < BeatsLeft) && (!GBACT_Val || ACTGB_Rdy), giving a one-deep register slice.
    - Full throughput is one beat per cycle.
    - Each source handshake loads GBACT_Data and sets GBACT_Val.
    - Each PEB handshake without a new load clears GBACT_Val.
    - Once all BeatsLeft beats have been handshaken to the PEB, go to NEXT.
  - NEXT: decrement the block counter.
    - Result 0 → Done=1 for one cycle, Busy=0, go to IDLE.
    - Otherwise go to FETCH_FLG.
- Flag and ACT channels are never valid simultaneously toward the PEB. The flag always precedes its activations.
- SrcACT_Rdy=0 outside SEND_ACT; SrcFLG_Rdy=0 outside FETCH_FLG.
- CfgStart while Busy=1 is ignored.
- Popcount counts over all FLG_WIDTH bits. A flag of all ones yields ceil(32/16)=2 beats.
- Block counter is CNT_WIDTH bits. A maximum NumBlk of 65535 sends 65535 blocks with no wrap.

Optional Feature:
- Macro: GB_ACT_SENDER_STAT_EN.
- Defined:
  - adds output StatActBeats (32 bits), counting PEB-side ACT handshakes;
  - clears on accepted CfgStart and on Rst;
  - saturates at 0xFFFFFFFF;
  - adds output StatFlgCnt (CNT_WIDTH bits), counting flag handshakes.
- Undefined: neither port exists and there is no counter logic.

Test Plan:
- NumBlk=1, flag=0x0000FFFF, one ACT beat, rdy always 1 → 1 flag handshake, then 1 ACT handshake with GBACT_Data equal to source beat; Done pulse; Busy low next cycle.
- NumBlk=3, flags 0x00000000, 0xFFFFFFFF, 0x00000001 → ACT beat counts 0, 2, 1; exactly 3 ACT handshakes total; flag order preserved.
- Flag 0xFFFFFFFF, ACTGB_Rdy toggling 1/0 each cycle → 2 ACT handshakes, GBACT_Data stable while stalled, no beat dropped or duplicated.
- NumBlk=0 start → Done one cycle after start, no val asserted on any PEB channel.
- Rst asserted in SEND_ACT after first beat → all outputs 0 immediately, no Done; new start with NumBlk=1 completes normally.
- STAT_EN defined, flags 0xFFFF0000 ×2 → StatActBeats=2, StatFlgCnt=2; reset by next CfgStart to 0.
